// File: rtl/rvb_shifter_issue.sv
// Issue stage for a bit-manipulation shifter: one operand register plus a 4-deep tag FIFO
// for in-order writeback. Define RVB_SHIFTER_ISSUE_DECODE_CHECK_EN to reject non-shift opcodes.
module rvb_shifter_issue #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_insn,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs3,
  input  logic [TAGW-1:0] req_tag,
  output logic            din_valid,
  input  logic            din_ready,
  output logic [XLEN-1:0] din_rs1,
  output logic [XLEN-1:0] din_rs2,
  output logic [XLEN-1:0] din_rs3,
  output logic            din_insn3,
  output logic            din_insn12,
  output logic            din_insn14,
  output logic            din_insn26,
  output logic            din_insn27,
  output logic            din_insn29,
  output logic            din_insn30,
  input  logic            dout_valid,
  output logic            dout_ready,
  input  logic [XLEN-1:0] dout_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_rd,
  output logic [TAGW-1:0] wb_tag,
  output logic            wb_illegal
);

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            illegal;
  } tag_entry_t;

  logic            iss_valid_q;
  logic [XLEN-1:0] iss_rs1_q, iss_rs2_q, iss_rs3_q;
  logic [6:0]      iss_bits_q;   // {insn30, insn29, insn27, insn26, insn14, insn12, insn3}

  tag_entry_t      fifo_mem [DEPTH];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;

  logic            req_illegal;
  logic            req_fire, din_fire, push, pop;
  logic            fifo_empty, fifo_full;
  tag_entry_t      head;
  logic            head_illegal;
  logic            unused_sink;

`ifdef RVB_SHIFTER_ISSUE_DECODE_CHECK_EN
  logic op_ok;
  logic f3_ok;
  always_comb begin
    op_ok = (req_insn[6:0] == 7'h33) || (req_insn[6:0] == 7'h13) ||
            ((XLEN == 64) && ((req_insn[6:0] == 7'h3B) || (req_insn[6:0] == 7'h1B)));
    f3_ok = (req_insn[14:12] == 3'b001) || (req_insn[14:12] == 3'b101);
    req_illegal = !(op_ok && f3_ok);
  end
  assign head_illegal = !fifo_empty && head.illegal;
`else
  assign req_illegal  = 1'b0;
  assign head_illegal = 1'b0;
`endif

  // Only a subset of instruction bits is consumed; fold the rest so lint sees them used.
  assign unused_sink = ^{req_insn, head};

  assign fifo_empty = (cnt_q == 3'd0);
  assign fifo_full  = (cnt_q == 3'd4);
  assign head       = fifo_mem[rd_ptr_q];

  // Gated by reset so the upstream sees no acceptance while reset is held.
  assign req_ready  = reset && !fifo_full && (!iss_valid_q || din_ready);
  assign req_fire   = req_valid && req_ready;
  assign din_fire   = iss_valid_q && din_ready;
  assign push       = req_fire;

  assign wb_valid   = !fifo_empty && (head_illegal || dout_valid);
  assign wb_tag     = fifo_empty ? '0 : head.tag;
  assign wb_illegal = head_illegal;
  assign wb_rd      = (!fifo_empty && !head_illegal) ? dout_rd : '0;
  assign dout_ready = wb_ready && !fifo_empty && !head_illegal;
  assign pop        = wb_valid && wb_ready;

  assign din_valid  = iss_valid_q;
  assign din_rs1    = iss_rs1_q;
  assign din_rs2    = iss_rs2_q;
  assign din_rs3    = iss_rs3_q;
  assign din_insn30 = iss_bits_q[6];
  assign din_insn29 = iss_bits_q[5];
  assign din_insn27 = iss_bits_q[4];
  assign din_insn26 = iss_bits_q[3];
  assign din_insn14 = iss_bits_q[2];
  assign din_insn12 = iss_bits_q[1];
  assign din_insn3  = iss_bits_q[0];

  // Issue register: a new legal request may load in the same cycle the old one leaves.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iss_valid_q <= 1'b0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_rs3_q   <= '0;
      iss_bits_q  <= '0;
    end else if (req_fire && !req_illegal) begin
      iss_valid_q <= 1'b1;
      iss_rs1_q   <= req_rs1;
      iss_rs2_q   <= req_rs2;
      iss_rs3_q   <= req_rs3;
      iss_bits_q  <= {req_insn[30], req_insn[29], req_insn[27], req_insn[26],
                      req_insn[14], req_insn[12], (XLEN == 64) ? req_insn[3] : 1'b0};
    end else if (din_fire) begin
      iss_valid_q <= 1'b0;
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; every read is qualified by occupancy.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= '{tag: req_tag, illegal: req_illegal};
  end

endmodule

// File: tb/tb_rvb_shifter_issue.sv
// Directed bench for rvb_shifter_issue: issue latency, illegal bypass, ordering,
// FIFO-full back-pressure and mid-operation reset. Honours RVB_SHIFTER_ISSUE_DECODE_CHECK_EN.
module tb_rvb_shifter_issue;
  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam logic [31:0] INSN_SLL = 32'h00209033;
  localparam logic [31:0] INSN_SRL = 32'h0020D033;
  localparam logic [31:0] INSN_ADD = 32'h00208033;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid, req_ready;
  logic [31:0]     req_insn;
  logic [XLEN-1:0] req_rs1, req_rs2, req_rs3;
  logic [TAGW-1:0] req_tag;
  logic            din_valid, din_ready;
  logic [XLEN-1:0] din_rs1, din_rs2, din_rs3;
  logic            din_insn3, din_insn12, din_insn14, din_insn26, din_insn27, din_insn29, din_insn30;
  logic            dout_valid, dout_ready;
  logic [XLEN-1:0] dout_rd;
  logic            wb_valid, wb_ready;
  logic [XLEN-1:0] wb_rd;
  logic [TAGW-1:0] wb_tag;
  logic            wb_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rvb_shifter_issue #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_tag(req_tag),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3),
    .din_insn3(din_insn3), .din_insn12(din_insn12), .din_insn14(din_insn14),
    .din_insn26(din_insn26), .din_insn27(din_insn27), .din_insn29(din_insn29),
    .din_insn30(din_insn30),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_rd(dout_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .wb_illegal(wb_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_insn   = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_rs3    = '0;
    req_tag    = '0;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_rd    = '0;
    wb_ready   = 1'b0;
  endtask

  task automatic send(input logic [31:0] insn, input logic [TAGW-1:0] tag);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = 32'h1;
    req_rs2   = 32'h4;
    req_rs3   = 32'h0;
    req_tag   = tag;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_din_valid", din_valid, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_dout_ready", dout_ready, 1'b0);
    check("rst_wb_fields", {wb_rd, wb_tag, wb_illegal}, '0);
    check("rst_din_rs1", din_rs1, '0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("rel_req_ready", req_ready, 1'b1);

    // Legal SLL, tag 3: issue one cycle after acceptance, result 0x10 written back.
    @(negedge clock);
    send(INSN_SLL, 5'd3);
    #1 check("t1_req_ready", req_ready, 1'b1);
    check("t1_din_idle", din_valid, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    #1 check("t1_din_valid", din_valid, 1'b1);
    check("t1_din_rs1", din_rs1, 32'h1);
    check("t1_din_rs2", din_rs2, 32'h4);
    check("t1_din_bits", {din_insn30, din_insn29, din_insn27, din_insn26, din_insn14, din_insn12, din_insn3}, 7'b0000010);
    check("t1_wb_wait", wb_valid, 1'b0);
    din_ready = 1'b1;
    @(negedge clock);
    din_ready = 1'b0;
    #1 check("t1_din_done", din_valid, 1'b0);
    dout_valid = 1'b1;
    dout_rd    = 32'h10;
    #1 check("t1_wb_valid", wb_valid, 1'b1);
    check("t1_wb_rd", wb_rd, 32'h10);
    check("t1_wb_tag", wb_tag, 5'd3);
    check("t1_wb_illegal", wb_illegal, 1'b0);
    check("t1_dout_ready_lo", dout_ready, 1'b0);
    wb_ready = 1'b1;
    #1 check("t1_dout_ready_hi", dout_ready, 1'b1);
    @(negedge clock);
    idle();
    #1 check("t1_wb_drained", wb_valid, 1'b0);

    // ADD, tag 7: rejected by the decode check, otherwise issued like any request.
    @(negedge clock);
    send(INSN_ADD, 5'd7);
    #1 check("t2_req_ready", req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
`ifdef RVB_SHIFTER_ISSUE_DECODE_CHECK_EN
    #1 check("t2_no_din", din_valid, 1'b0);
    check("t2_wb_valid", wb_valid, 1'b1);
    check("t2_wb_rd", wb_rd, 32'h0);
    check("t2_wb_tag", wb_tag, 5'd7);
    check("t2_wb_illegal", wb_illegal, 1'b1);
    check("t2_dout_ready", dout_ready, 1'b0);
    wb_ready = 1'b1;
`else
    #1 check("t2_din_valid", din_valid, 1'b1);
    check("t2_wb_wait", wb_valid, 1'b0);
    din_ready  = 1'b1;
    dout_valid = 1'b1;
    dout_rd    = 32'h55;
    wb_ready   = 1'b1;
    #1 check("t2_wb_tag", wb_tag, 5'd7);
    check("t2_wb_rd", wb_rd, 32'h55);
    check("t2_wb_illegal", wb_illegal, 1'b0);
`endif
    @(negedge clock);
    idle();
    #1 check("t2_wb_drained", wb_valid, 1'b0);

    // Tags 1 (legal), 2 (ADD), 3 (legal); shifter answers only after 5 idle cycles.
    @(negedge clock);
    din_ready = 1'b1;
    send(INSN_SLL, 5'd1);
    #1 check("t3_acc1", req_ready, 1'b1);
    @(negedge clock);
    send(INSN_ADD, 5'd2);
    #1 check("t3_acc2", req_ready, 1'b1);
    @(negedge clock);
    send(INSN_SRL, 5'd3);
    #1 check("t3_acc3", req_ready, 1'b1);
    @(negedge clock);
    req_valid = 1'b0;
    wb_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("t3_hold_wb", wb_valid, 1'b0);
      check("t3_hold_tag", wb_tag, 5'd1);
      @(negedge clock);
    end
    dout_valid = 1'b1;
    dout_rd    = 32'hA1;
    #1 check("t3_wb1_valid", wb_valid, 1'b1);
    check("t3_wb1_tag", wb_tag, 5'd1);
    check("t3_wb1_rd", wb_rd, 32'hA1);
    @(negedge clock);
`ifdef RVB_SHIFTER_ISSUE_DECODE_CHECK_EN
    dout_valid = 1'b0;
    #1 check("t3_wb2_valid", wb_valid, 1'b1);
    check("t3_wb2_illegal", wb_illegal, 1'b1);
    check("t3_wb2_dout_ready", dout_ready, 1'b0);
`else
    dout_rd = 32'hA2;
    #1 check("t3_wb2_valid", wb_valid, 1'b1);
    check("t3_wb2_rd", wb_rd, 32'hA2);
`endif
    check("t3_wb2_tag", wb_tag, 5'd2);
    @(negedge clock);
    dout_valid = 1'b1;
    dout_rd    = 32'hA3;
    #1 check("t3_wb3_valid", wb_valid, 1'b1);
    check("t3_wb3_tag", wb_tag, 5'd3);
    check("t3_wb3_rd", wb_rd, 32'hA3);
    @(negedge clock);
    idle();
    #1 check("t3_drained", wb_valid, 1'b0);

    // Writeback stalled: exactly four requests fit, then drain in order and resume.
    din_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      send(INSN_SLL, 5'(10 + ((i < 4) ? i : 4)));
      #1 check("t4_req_ready", req_ready, (i < 4) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 2) req_valid = 1'b0;
      wb_ready   = 1'b1;
      dout_valid = 1'b1;
      dout_rd    = 32'h100 + 32'(k);
      #1 check("t4_wb_valid", wb_valid, 1'b1);
      check("t4_wb_tag", wb_tag, 5'(10 + k));
      check("t4_wb_rd", wb_rd, 32'h100 + 32'(k));
      if (k == 0) check("t4_full_ready", req_ready, 1'b0);
      if (k == 1) check("t4_resume_ready", req_ready, 1'b1);
    end
    @(negedge clock);
    idle();
    #1 check("t4_drained", wb_valid, 1'b0);

    // Reset with three tags in flight.
    din_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      send(INSN_SLL, 5'(20 + i));
      #1 check("t5_acc", req_ready, 1'b1);
    end
    @(negedge clock);
    req_valid  = 1'b0;
    din_ready  = 1'b0;
    dout_valid = 1'b1;
    dout_rd    = 32'hBEEF;
    #1 check("t5_pre_wb", wb_valid, 1'b1);
    check("t5_pre_tag", wb_tag, 5'd20);
    check("t5_pre_din", din_valid, 1'b1);
    #1 reset = 1'b0;
    #1 check("t5_rst_req_ready", req_ready, 1'b0);
    check("t5_rst_din_valid", din_valid, 1'b0);
    check("t5_rst_wb_valid", wb_valid, 1'b0);
    check("t5_rst_wb_fields", {wb_rd, wb_tag, wb_illegal}, '0);
    check("t5_rst_din_rs1", din_rs1, '0);
    @(negedge clock);
    wb_ready = 1'b1;
    reset    = 1'b1;
    #1 check("t5_rel_req_ready", req_ready, 1'b1);
    check("t5_rel_wb_valid", wb_valid, 1'b0);
    check("t5_rel_dout_ready", dout_ready, 1'b0);
    @(negedge clock);
    #1 check("t5_no_stale_wb", wb_valid, 1'b0);
    check("t5_no_stale_din", din_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
